// File: rtl/primegen_sched.sv
`default_nettype none
// ============================================================================
// Module   : primegen_sched
// Brief    : Round-robin scheduler sharing one primegen among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module primegen_sched #(
    parameter int NREQ = 4,
    parameter int IW   = 8,
    parameter int W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*IW-1:0]      req_idx,
    output logic [NREQ-1:0]         ack,
    output logic                    resp_valid,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [W-1:0]            resp_prime,
    output logic                    resp_error,
    output logic                    busy,
    output logic                    gen_go,
    output logic                    gen_rst,
    input  logic                    gen_ready,
    input  logic                    gen_error,
    input  logic [W-1:0]            gen_res
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_check     = 3'd1;
    localparam logic [2:0] c_st_grst      = 3'd2;
    localparam logic [2:0] c_st_grst_wait = 3'd3;
    localparam logic [2:0] c_st_step      = 3'd4;
    localparam logic [2:0] c_st_step_lo   = 3'd5;
    localparam logic [2:0] c_st_step_hi   = 3'd6;
    localparam logic [2:0] c_st_resp      = 3'd7;

    logic [2:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_sel;
    logic [IW-1:0]  r_tgt;
    logic [IW:0]    r_cur;
    logic           r_known;
    logic           r_err;

    logic           w_any;
    logic [IDW-1:0] w_pick;
    logic [IDW-1:0] w_cand;
    logic [IW:0]    w_tgt_ext;
    logic [IDW-1:0] w_rr_next;

    // Scan from the highest offset down so the last hit is the one closest to rr_ptr.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IDW'((32'(r_rr_ptr) + 32'(k)) % 32'(NREQ));
            if (req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_tgt_ext = {1'b0, r_tgt};
    assign w_rr_next = (r_sel == IDW'(NREQ - 1)) ? '0 : r_sel + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= '0;
            r_sel    <= '0;
            r_tgt    <= '0;
            r_cur    <= '0;
            r_known  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_sel   <= w_pick;
                        r_tgt   <= req_idx[w_pick*IW +: IW];
                        r_err   <= 1'b0;
                        r_state <= c_st_check;
                    end
                end
                c_st_check: begin
                    if (!r_known || (w_tgt_ext < r_cur)) begin
                        r_state <= c_st_grst;
                    end else if (w_tgt_ext == r_cur) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_state <= c_st_step;
                    end
                end
                c_st_grst: begin
                    r_state <= c_st_grst_wait;
                end
                c_st_grst_wait: begin
                    if (gen_ready) begin
                        r_cur   <= '0;
                        r_known <= 1'b1;
                        r_state <= c_st_check;
                    end
                end
                // gen_go is qualified by gen_ready, so hold here until the generator is free.
                c_st_step: begin
                    if (gen_ready) begin
                        r_state <= c_st_step_lo;
                    end
                end
                c_st_step_lo: begin
                    if (!gen_ready) begin
                        r_state <= c_st_step_hi;
                    end
                end
                c_st_step_hi: begin
                    if (gen_ready) begin
                        if (gen_error) begin
                            r_known <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= c_st_resp;
                        end else begin
                            r_cur   <= r_cur + 1'b1;
                            r_state <= c_st_check;
                        end
                    end
                end
                c_st_resp: begin
                    r_rr_ptr <= w_rr_next;
                    r_state  <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_st_idle);
    assign gen_go     = (r_state == c_st_step) && gen_ready;
    assign gen_rst    = (r_state == c_st_grst);
    assign resp_valid = (r_state == c_st_resp);
    assign ack        = resp_valid ? (NREQ'(1) << r_sel) : '0;
    assign resp_id    = resp_valid ? r_sel : '0;
    assign resp_prime = (resp_valid && !r_err) ? gen_res : '0;
    assign resp_error = resp_valid && r_err;

endmodule
`default_nettype wire
